// File: rtl/spi_xfer_sequencer_if.sv
// Command/TX/RX streams and spi_master side-band bundled for spi_xfer_sequencer.
// The slave modport is the sequencer's view; master is the surrounding system.
interface spi_xfer_sequencer_if #(
  parameter int LEN_W = 5
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic [1:0]       cmd_mode;
  logic             tx_valid;
  logic             tx_ready;
  logic [7:0]       tx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [7:0]       rx_data;
  logic             spi_start;
  logic [7:0]       spi_data;
  logic [1:0]       spi_mode;
  logic             spi_done;
  logic [7:0]       spi_rdata;

  modport slave (
    input  cmd_valid, cmd_len, cmd_mode, tx_valid, tx_data, rx_ready, spi_done, spi_rdata,
    output cmd_ready, tx_ready, rx_valid, rx_data, spi_start, spi_data, spi_mode
  );

  modport master (
    output cmd_valid, cmd_len, cmd_mode, tx_valid, tx_data, rx_ready, spi_done, spi_rdata,
    input  cmd_ready, tx_ready, rx_valid, rx_data, spi_start, spi_data, spi_mode
  );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// Burst sequencer in front of spi_master: one transfer per TX byte, RX bytes into a FWFT FIFO.
// Optional WAIT watchdog enabled by defining SPI_SEQ_TIMEOUT_EN.
module spi_xfer_sequencer #(
  parameter int MAX_LEN  = 16,
  parameter int LEN_W    = $clog2(MAX_LEN + 1),
  parameter int RX_DEPTH = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  spi_xfer_sequencer_if.slave     bus,
  output logic                    busy_o,
  output logic                    err_len_o,
  output logic                    err_timeout_o
);
  localparam int PTR_W = $clog2(RX_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if ((RX_DEPTH < 2) || ((RX_DEPTH & (RX_DEPTH - 1)) != 0) || (MAX_LEN < 1) || (TIMEOUT < 1))
  begin : g_bad_cfg
    $error("spi_xfer_sequencer: illegal parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_START, S_WAIT} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [1:0]       mode_q, mode_d;
  logic [7:0]       data_q, data_d;
  logic             err_len_q, err_len_d;

  logic [7:0]       mem_q [RX_DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] cnt_q;

  logic cmd_hs, tx_hs, len_ok, push, pop, timeout_hit;

  assign bus.cmd_ready = (state_q == S_IDLE);
  // TX is only taken when the FIFO can absorb the byte this transfer will return
  assign bus.tx_ready  = (state_q == S_FETCH) && (cnt_q < CNT_W'(RX_DEPTH));
  assign bus.spi_start = (state_q == S_START);
  assign bus.spi_data  = data_q;
  assign bus.spi_mode  = mode_q;
  assign bus.rx_valid  = (cnt_q != '0);
  assign bus.rx_data   = bus.rx_valid ? mem_q[rptr_q] : 8'h00;

  assign cmd_hs = bus.cmd_valid & bus.cmd_ready;
  assign tx_hs  = bus.tx_valid & bus.tx_ready;
  assign pop    = bus.rx_valid & bus.rx_ready;
  assign len_ok = (bus.cmd_len != '0) && (bus.cmd_len <= LEN_W'(MAX_LEN));

  assign busy_o    = (state_q != S_IDLE);
  assign err_len_o = err_len_q;

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] wcnt_q, wcnt_d;

  // Counter is zero on WAIT entry, so TIMEOUT-1 marks the TIMEOUT-th WAIT cycle
  always_comb begin
    wcnt_d = '0;
    if (state_q == S_WAIT) wcnt_d = wcnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) wcnt_q <= '0;
    else       wcnt_q <= wcnt_d;
  end

  assign timeout_hit   = (state_q == S_WAIT) && !bus.spi_done && (wcnt_q == TO_W'(TIMEOUT - 1));
  assign err_timeout_o = timeout_hit;
`else
  assign timeout_hit   = 1'b0;
  assign err_timeout_o = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    mode_d    = mode_q;
    data_d    = data_q;
    err_len_d = 1'b0;
    push      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_hs) begin
          if (len_ok) begin
            rem_d   = bus.cmd_len;
            mode_d  = bus.cmd_mode;
            state_d = S_FETCH;
          end else begin
            err_len_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (tx_hs) begin
          data_d  = bus.tx_data;
          state_d = S_START;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.spi_done) begin
          push    = 1'b1;
          rem_d   = rem_q - LEN_W'(1);
          state_d = (rem_q == LEN_W'(1)) ? S_IDLE : S_FETCH;
        end else if (timeout_hit) begin
          rem_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      mode_q    <= '0;
      data_q    <= '0;
      err_len_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      mode_q    <= mode_d;
      data_q    <= data_d;
      err_len_q <= err_len_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= bus.spi_rdata;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule
